// File: rtl/vga_pkg.sv
// Default raster timing (640x480@60) and the encoding of the four
// screen-position adjustment directions.
package vga_pkg;

  localparam int unsigned VGA_CW     = 12;
  localparam int unsigned VGA_H_DISP = 640;
  localparam int unsigned VGA_H_FP   = 16;
  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP   = 48;
  localparam int unsigned VGA_V_DISP = 480;
  localparam int unsigned VGA_V_FP   = 10;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP   = 33;

  localparam int unsigned ADJ_N = 4;

  typedef enum logic [1:0] {
    ADJ_UP    = 2'd0,
    ADJ_DOWN  = 2'd1,
    ADJ_LEFT  = 2'd2,
    ADJ_RIGHT = 2'd3
  } adj_dir_e;

  function automatic int unsigned vga_total(input int unsigned disp,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return disp + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_porch_ctrl.sv
// Holds the live porch registers and the sticky adjustment requests; moves
// the image by one pixel/line per axis when the frame boundary is signalled.
module vga_porch_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned CW        = VGA_CW,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter int unsigned MIN_PORCH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [ADJ_N-1:0] adj_i,
  input  logic             apply_i,
  output logic [CW-1:0]    hfp_o,
  output logic [CW-1:0]    hbp_o,
  output logic [CW-1:0]    vfp_o,
  output logic [CW-1:0]    vbp_o
);

  localparam logic [CW-1:0] MIN_C = CW'(MIN_PORCH);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [ADJ_N-1:0] pend_q, pend_d;
  logic [CW-1:0]    hfp_q, hfp_d;
  logic [CW-1:0]    hbp_q, hbp_d;
  logic [CW-1:0]    vfp_q, vfp_d;
  logic [CW-1:0]    vbp_q, vbp_d;
  logic             go_right, go_left, go_up, go_down;

  // Opposing requests on the same axis cancel; each move is refused if it
  // would shrink the donor porch below the minimum.
  assign go_right = pend_q[ADJ_RIGHT] & ~pend_q[ADJ_LEFT] & (hfp_q > MIN_C);
  assign go_left  = pend_q[ADJ_LEFT]  & ~pend_q[ADJ_RIGHT] & (hbp_q > MIN_C);
  assign go_up    = pend_q[ADJ_UP]    & ~pend_q[ADJ_DOWN] & (vbp_q > MIN_C);
  assign go_down  = pend_q[ADJ_DOWN]  & ~pend_q[ADJ_UP]   & (vfp_q > MIN_C);

  always_comb begin
    pend_d = apply_i ? adj_i : (pend_q | adj_i);
    hfp_d  = hfp_q;
    hbp_d  = hbp_q;
    vfp_d  = vfp_q;
    vbp_d  = vbp_q;
    if (apply_i) begin
      if (go_right) begin
        hfp_d = hfp_q - ONE;
        hbp_d = hbp_q + ONE;
      end else if (go_left) begin
        hfp_d = hfp_q + ONE;
        hbp_d = hbp_q - ONE;
      end
      if (go_up) begin
        vfp_d = vfp_q + ONE;
        vbp_d = vbp_q - ONE;
      end else if (go_down) begin
        vfp_d = vfp_q - ONE;
        vbp_d = vbp_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      hfp_q  <= CW'(H_FP);
      hbp_q  <= CW'(H_BP);
      vfp_q  <= CW'(V_FP);
      vbp_q  <= CW'(V_BP);
    end else begin
      pend_q <= pend_d;
      hfp_q  <= hfp_d;
      hbp_q  <= hbp_d;
      vfp_q  <= vfp_d;
      vbp_q  <= vbp_d;
    end
  end

  assign hfp_o = hfp_q;
  assign hbp_o = hbp_q;
  assign vfp_o = vfp_q;
  assign vbp_o = vbp_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel clock-enable divider,
// programmable sync polarity and frame-synchronous screen position adjustment.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CW        = VGA_CW,
  parameter int unsigned H_DISP    = VGA_H_DISP,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_DISP    = VGA_V_DISP,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter logic        HS_POL    = 1'b0,
  parameter logic        VS_POL    = 1'b0,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned MIN_PORCH = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          adj_up_i,
  input  logic          adj_down_i,
  input  logic          adj_left_i,
  input  logic          adj_right_i,
  output logic          pix_tick_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          video_on_o,
  output logic [CW-1:0] pixel_x_o,
  output logic [CW-1:0] pixel_y_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  localparam int unsigned H_TOTAL = vga_total(H_DISP, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = vga_total(V_DISP, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0]    H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]    H_DISP_C  = CW'(H_DISP);
  localparam logic [CW-1:0]    V_DISP_C  = CW'(V_DISP);
  localparam logic [CW-1:0]    H_TOTAL_C = CW'(H_TOTAL);
  localparam logic [CW-1:0]    V_TOTAL_C = CW'(V_TOTAL);
  localparam logic [CW-1:0]    ONE       = CW'(1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CW-1:0]    h_q, h_d;
  logic [CW-1:0]    v_q, v_d;
  logic             started_q, started_d;

  logic             pix_tick_q, hsync_q, vsync_q, video_on_q;
  logic             line_start_q, frame_start_q;
  logic             hsync_d, vsync_d, video_on_d;

  logic             tick, h_last, v_last, h_wrap, apply;
  logic [ADJ_N-1:0] adj;
  logic [CW-1:0]    hfp, hbp, vfp, vbp;
  logic [CW-1:0]    hs_start, hs_end, vs_start, vs_end;

  always_comb begin
    adj            = '0;
    adj[ADJ_UP]    = adj_up_i;
    adj[ADJ_DOWN]  = adj_down_i;
    adj[ADJ_LEFT]  = adj_left_i;
    adj[ADJ_RIGHT] = adj_right_i;
  end

  // With CLK_DIV=1 the divider never leaves 0, so every clk is a tick.
  assign tick   = (div_q == DIV_LAST);
  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);
  assign h_wrap = tick & started_q & h_last;
  assign apply  = h_wrap & v_last;

  // The first tick after reset only arms the raster so that pixel (0,0)
  // gets its full period instead of being consumed during reset.
  always_comb begin
    div_d     = div_q;
    h_d       = h_q;
    v_d       = v_q;
    started_d = started_q;
    if (tick) begin
      div_d     = '0;
      started_d = 1'b1;
      if (started_q) begin
        if (h_last) begin
          h_d = '0;
          v_d = v_last ? '0 : (v_q + ONE);
        end else begin
          h_d = h_q + ONE;
        end
      end
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  // Sync windows start after the front porch and end where the back porch
  // begins, so both porch registers position the pulse.
  assign hs_start = H_DISP_C + hfp;
  assign hs_end   = H_TOTAL_C - hbp;
  assign vs_start = V_DISP_C + vfp;
  assign vs_end   = V_TOTAL_C - vbp;

  always_comb begin
    hsync_d    = ((h_d >= hs_start) && (h_d < hs_end)) ? HS_POL : ~HS_POL;
    vsync_d    = ((v_d >= vs_start) && (v_d < vs_end)) ? VS_POL : ~VS_POL;
    video_on_d = started_d && (h_d < H_DISP_C) && (v_d < V_DISP_C);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      started_q     <= 1'b0;
      pix_tick_q    <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      started_q     <= started_d;
      pix_tick_q    <= tick;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= h_wrap;
      frame_start_q <= apply;
    end
  end

  vga_porch_ctrl #(
    .CW        (CW),
    .H_FP      (H_FP),
    .H_BP      (H_BP),
    .V_FP      (V_FP),
    .V_BP      (V_BP),
    .MIN_PORCH (MIN_PORCH)
  ) u_porch (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .adj_i   (adj),
    .apply_i (apply),
    .hfp_o   (hfp),
    .hbp_o   (hbp),
    .vfp_o   (vfp),
    .vbp_o   (vbp)
  );

  assign pix_tick_o    = pix_tick_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign video_on_o    = video_on_q;
  assign pixel_x_o     = h_q;
  assign pixel_y_o     = v_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule
